// File: rtl/i2s_receive.sv
// I2S serial capture into AXI4-Stream stereo pairs (left beat TLAST=0, right beat TLAST=1).
// sck/ws/sd are synchronized into the ACLK domain and only edge-detected, never used as clocks.
module i2s_receive #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic                  overrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]         CNT_MAX  = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;

    logic                  sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic                  ws_meta_q, ws_meta_d, ws_sync_q, ws_sync_d;
    logic                  sd_meta_q, sd_meta_d, sd_sync_q, sd_sync_d;
    logic                  ws_prev_q, ws_prev_d, ws_seen_q, ws_seen_d;
    logic                  locked_q, locked_d, left_valid_q, left_valid_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d, right_hold_q, right_hold_d;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d, tvalid_q, tvalid_d, overrun_q, overrun_d;

    logic                  sck_rise_s, slot_end_s, left_done_s, right_done_s;
    logic [DATA_WIDTH-1:0] bit_mask_s, shift_bit_s;

    // Next-state logic: synchronizers, slot capture, pair hand-off and output FSM.
    always_comb begin
        sck_meta_d   = sck;
        sck_sync_d   = sck_meta_q;
        sck_prev_d   = sck_sync_q;
        ws_meta_d    = ws;
        ws_sync_d    = ws_meta_q;
        sd_meta_d    = sd;
        sd_sync_d    = sd_meta_q;
        ws_prev_d    = ws_prev_q;
        ws_seen_d    = ws_seen_q;
        locked_d     = locked_q;
        left_valid_d = left_valid_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        state_d      = state_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
        overrun_d    = 1'b0;

        sck_rise_s  = sck_sync_q & ~sck_prev_q;
        bit_mask_s  = MSB_MASK >> bit_cnt_q;
        // Word including the bit sampled on this edge; bits past DATA_WIDTH fall off (mask is zero).
        if (sd_sync_q && (bit_cnt_q < CNT_MAX)) begin
            shift_bit_s = shift_q | bit_mask_s;
        end else begin
            shift_bit_s = shift_q;
        end
        slot_end_s   = sck_rise_s && ws_seen_q && (ws_sync_q != ws_prev_q);
        left_done_s  = slot_end_s && locked_q && !ws_prev_q;
        right_done_s = slot_end_s && locked_q && ws_prev_q && left_valid_q;

        if (sck_rise_s) begin
            ws_prev_d = ws_sync_q;
            ws_seen_d = 1'b1;
            if (slot_end_s) begin
                shift_d   = ZERO_W;
                bit_cnt_d = {CW{1'b0}};
                locked_d  = 1'b1;
            end else begin
                shift_d = shift_bit_s;
                if (bit_cnt_q < CNT_MAX) begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
        end else begin
            ws_prev_d = ws_prev_q;
        end

        // A right slot pairs only with the left slot that ended directly before it.
        if (left_done_s) begin
            left_hold_d  = shift_bit_s;
            left_valid_d = 1'b1;
        end else if (slot_end_s) begin
            left_valid_d = 1'b0;
        end else begin
            left_valid_d = left_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (right_done_s) begin
                    right_hold_d = shift_bit_s;
                    tdata_d      = left_hold_q;
                    tlast_d      = 1'b0;
                    tvalid_d     = 1'b1;
                    state_d      = ST_LEFT;
                end else begin
                    tvalid_d = 1'b0;
                end
            end
            ST_LEFT: begin
                if (M_AXIS_TREADY) begin
                    tdata_d = right_hold_q;
                    tlast_d = 1'b1;
                    state_d = ST_RIGHT;
                end else begin
                    state_d = ST_LEFT;
                end
            end
            ST_RIGHT: begin
                if (M_AXIS_TREADY) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RIGHT;
                end
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Busy includes the cycle of the final RIGHT handshake.
        if (right_done_s && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_prev_q   <= 1'b0;
            ws_meta_q    <= 1'b0;
            ws_sync_q    <= 1'b0;
            sd_meta_q    <= 1'b0;
            sd_sync_q    <= 1'b0;
            ws_prev_q    <= 1'b0;
            ws_seen_q    <= 1'b0;
            locked_q     <= 1'b0;
            left_valid_q <= 1'b0;
            bit_cnt_q    <= {CW{1'b0}};
            shift_q      <= ZERO_W;
            left_hold_q  <= ZERO_W;
            right_hold_q <= ZERO_W;
            state_q      <= ST_IDLE;
            tdata_q      <= ZERO_W;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sck_meta_q   <= sck_meta_d;
            sck_sync_q   <= sck_sync_d;
            sck_prev_q   <= sck_prev_d;
            ws_meta_q    <= ws_meta_d;
            ws_sync_q    <= ws_sync_d;
            sd_meta_q    <= sd_meta_d;
            sd_sync_q    <= sd_sync_d;
            ws_prev_q    <= ws_prev_d;
            ws_seen_q    <= ws_seen_d;
            locked_q     <= locked_d;
            left_valid_q <= left_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            state_q      <= state_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_i2s_receive.sv
// Directed bench for i2s_receive: a 32-bit and a 24-bit instance share one I2S stream;
// expected beats come from a slot-level pairing model plus hand-computed literals.
module tb_i2s_receive;

    logic        clk = 1'b0;
    logic        rstn, sck, ws, sd, trdy32, trdy24;
    logic [31:0] td32;
    logic [23:0] td24;
    logic        tl32, tv32, ov32, tl24, tv24, ov24;

    int vectors = 0;
    int miscompares = 0;
    int ovr_cnt32 = 0;
    int ovr_cnt24 = 0;

    typedef struct {
        logic        w;
        logic [63:0] word;
        int          len;
    } slot_t;

    slot_t       slots[$];
    logic [32:0] exp32[$];
    logic [24:0] exp24[$];
    logic [32:0] first_beat32;
    bit          first_seen32;

    always #5 clk = ~clk;

    i2s_receive #(.DATA_WIDTH(32)) dut32 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .M_AXIS_TDATA(td32), .M_AXIS_TLAST(tl32),
        .M_AXIS_TVALID(tv32), .M_AXIS_TREADY(trdy32), .sck(sck), .ws(ws), .sd(sd), .overrun(ov32)
    );

    i2s_receive #(.DATA_WIDTH(24)) dut24 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .M_AXIS_TDATA(td24), .M_AXIS_TLAST(tl24),
        .M_AXIS_TVALID(tv24), .M_AXIS_TREADY(trdy24), .sck(sck), .ws(ws), .sd(sd), .overrun(ov24)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Top 32 bits of a slot, MSB-first, left-justified (short slots zero-padded).
    function automatic logic [31:0] fit(input logic [63:0] word, input int len);
        logic [63:0] v;
        v = word << (64 - len);
        return v[63:32];
    endfunction

    task automatic add(input logic w, input logic [63:0] word, input int len);
        slot_t s;
        s.w = w; s.word = word; s.len = len;
        slots.push_back(s);
    endtask

    // Slot 0 is the partial slot before lock; the last slot never completes.
    task automatic model_push(input int drop_pair, input bit to32, input bit to24);
        logic [31:0] lw;
        logic [31:0] rw;
        bit have;
        int p;
        have = 1'b0; p = 0; lw = 32'h0;
        for (int k = 1; k < slots.size() - 1; k++) begin
            if (slots[k].w == 1'b0) begin
                lw = fit(slots[k].word, slots[k].len);
                have = 1'b1;
            end else if (have) begin
                have = 1'b0;
                rw = fit(slots[k].word, slots[k].len);
                if (p != drop_pair && to32) begin
                    exp32.push_back({1'b0, lw});
                    exp32.push_back({1'b1, rw});
                end
                if (to24) begin
                    exp24.push_back({1'b0, lw[31:8]});
                    exp24.push_back({1'b1, rw[31:8]});
                end
                p++;
            end
        end
    endtask

    // Ratio 8: sck low 4 ACLKs, high 4 ACLKs; ws leads the slot by one bit as in I2S.
    task automatic send_stream();
        logic sdb[$];
        logic wsb[$];
        for (int s = 0; s < slots.size(); s++) begin
            for (int i = 0; i < slots[s].len; i++) begin
                sdb.push_back(slots[s].word[slots[s].len - 1 - i]);
                wsb.push_back(slots[s].w);
            end
        end
        for (int j = 0; j < sdb.size(); j++) begin
            @(posedge clk); #2;
            sck = 1'b0;
            sd  = sdb[j];
            ws  = (j + 1 < wsb.size()) ? wsb[j + 1] : wsb[j];
            repeat (4) @(posedge clk);
            #2 sck = 1'b1;
            repeat (3) @(posedge clk);
        end
        @(posedge clk); #2 sck = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rstn = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        exp32.delete(); exp24.delete(); slots.delete();
        ovr_cnt32 = 0; ovr_cnt24 = 0;
    endtask

    task automatic wait_tv32(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (tv32) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic end_checks(input string tag, input int ovr_exp);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk({tag, "_pending32"}, 64'(exp32.size()), 64'd0);
        chk({tag, "_pending24"}, 64'(exp24.size()), 64'd0);
        chk({tag, "_overrun32"}, 64'(ovr_cnt32), 64'(ovr_exp));
        chk({tag, "_overrun24"}, 64'(ovr_cnt24), 64'd0);
    endtask

    // Scoreboard: beats at handshakes, stall stability, overrun pulse counting.
    initial begin
        logic        hold32, hold24, pl32, pl24;
        logic [31:0] pd32;
        logic [23:0] pd24;
        logic [32:0] e32;
        logic [24:0] e24;
        hold32 = 1'b0; hold24 = 1'b0; pl32 = 1'b0; pl24 = 1'b0; pd32 = 32'h0; pd24 = 24'h0;
        first_seen32 = 1'b0; first_beat32 = 33'h0;
        forever begin
            @(negedge clk);
            if (rstn !== 1'b1) begin
                hold32 = 1'b0; hold24 = 1'b0; first_seen32 = 1'b0;
            end else begin
                if (ov32) ovr_cnt32++;
                if (ov24) ovr_cnt24++;
                if (hold32) chk("stall_stable32", 64'({tv32, tl32, td32}), 64'({1'b1, pl32, pd32}));
                if (hold24) chk("stall_stable24", 64'({tv24, tl24, td24}), 64'({1'b1, pl24, pd24}));
                if (tv32 && trdy32) begin
                    if (exp32.size() == 0) begin
                        chk("beat32_unexpected", 64'({tl32, td32}), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e32 = exp32.pop_front();
                        chk("beat32", 64'({tl32, td32}), 64'(e32));
                    end
                    if (!first_seen32) begin
                        first_beat32 = {tl32, td32};
                        first_seen32 = 1'b1;
                    end
                end
                if (tv24 && trdy24) begin
                    if (exp24.size() == 0) begin
                        chk("beat24_unexpected", 64'({tl24, td24}), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e24 = exp24.pop_front();
                        chk("beat24", 64'({tl24, td24}), 64'(e24));
                    end
                end
                hold32 = tv32 && !trdy32; pd32 = td32; pl32 = tl32;
                hold24 = tv24 && !trdy24; pd24 = td24; pl24 = tl24;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rstn = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; trdy32 = 1'b1; trdy24 = 1'b1;

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("reset_outputs32", 64'({tv32, tl32, ov32, td32}), 64'd0);
        chk("reset_outputs24", 64'({tv24, tl24, ov24, td24}), 64'd0);

        // Basic: partial left, orphan right, then two full frames, always ready.
        add(1'b0, 64'h5, 3);
        add(1'b1, 64'h1234_5678, 32);
        add(1'b0, 64'hA5A5_0F0F, 32); add(1'b1, 64'h1234_5678, 32);
        add(1'b0, 64'hA5A5_0F0F, 32); add(1'b1, 64'h1234_5678, 32);
        add(1'b0, 64'h0, 2);
        model_push(-1, 1'b1, 1'b1);
        chk("model_basic_pairs", 64'(exp32.size()), 64'd4);
        send_stream();
        end_checks("basic", 0);
        chk("basic_first_beat", 64'(first_beat32), 64'({1'b0, 32'hA5A5_0F0F}));

        // Backpressure, also lock from ws=1 mid-slot.
        do_reset();
        trdy32 = 1'b0;
        add(1'b1, 64'h6, 3);
        add(1'b0, 64'hA5A5_0F0F, 32); add(1'b1, 64'h1234_5678, 32);
        add(1'b0, 64'h1, 2);
        model_push(-1, 1'b1, 1'b1);
        fork
            send_stream();
            begin
                wait_tv32(3000, ok);
                chk("bp_tvalid_seen", 64'(ok), 64'd1);
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("bp_held_beat", 64'({tv32, tl32, td32}), 64'({1'b1, 1'b0, 32'hA5A5_0F0F}));
                @(posedge clk); #2 trdy32 = 1'b1;
            end
        join
        end_checks("bp", 0);

        // Overrun: sink stalled across the second frame, which is dropped.
        do_reset();
        trdy32 = 1'b0;
        add(1'b1, 64'h3, 4);
        add(1'b0, 64'hA5A5_0F0F, 32); add(1'b1, 64'h1234_5678, 32);
        add(1'b0, 64'h1111_1111, 32); add(1'b1, 64'h2222_2222, 32);
        add(1'b0, 64'h3333_3333, 32); add(1'b1, 64'h4444_4444, 32);
        add(1'b0, 64'h0, 2);
        model_push(1, 1'b1, 1'b1);
        fork
            send_stream();
            begin
                ok = 1'b0;
                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
                    if (ovr_cnt32 > 0) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk("ovr_seen", 64'(ok), 64'd1);
                @(posedge clk); #2 trdy32 = 1'b1;
            end
        join
        end_checks("ovr", 1);

        // Width: 32-bit, 40-bit (extra bits ignored) and 16-bit (padded) slots.
        do_reset();
        add(1'b1, 64'h2, 3);
        add(1'b0, 64'hABCD_EF55, 32); add(1'b1, 64'h13_579B_DFAA, 40);
        add(1'b0, 64'hBEEF, 16);      add(1'b1, 64'h1234, 16);
        add(1'b0, 64'h0, 2);
        model_push(-1, 1'b1, 1'b0);
        exp24.push_back({1'b0, 24'hABCDEF});
        exp24.push_back({1'b1, 24'h13579B});
        exp24.push_back({1'b0, 24'hBEEF00});
        exp24.push_back({1'b1, 24'h123400});
        chk("model_width_short", 64'(exp32[2]), 64'({1'b0, 32'hBEEF_0000}));
        send_stream();
        end_checks("width", 0);

        // Reset while a beat is held, then re-lock on a fresh stream.
        do_reset();
        trdy32 = 1'b0;
        add(1'b1, 64'h1, 2);
        add(1'b0, 64'hCAFE_F00D, 32); add(1'b1, 64'h0BAD_BEEF, 32);
        add(1'b0, 64'h0, 2);
        model_push(-1, 1'b1, 1'b1);
        send_stream();
        wait_tv32(200, ok);
        chk("rst_mid_tvalid_before", 64'(ok), 64'd1);
        chk("rst_mid_pending32", 64'(exp32.size()), 64'd2);
        @(posedge clk); #2 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_tvalid_after", 64'({tv32, tv24}), 64'd0);
        do_reset();
        trdy32 = 1'b1;
        add(1'b0, 64'h7, 3);
        add(1'b1, 64'hFFFF_0000, 32);
        add(1'b0, 64'h0F0F_0F0F, 32); add(1'b1, 64'hF0F0_F0F0, 32);
        add(1'b1 ^ 1'b1, 64'h0, 2);
        model_push(-1, 1'b1, 1'b1);
        send_stream();
        end_checks("relock", 0);
        chk("relock_first_beat", 64'(first_beat32), 64'({1'b0, 32'h0F0F_0F0F}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
